led_display_ctrl: RTL and testbench
===================================

Name: led_display_ctrl

Overview:
- Downstream consumer of the single-cycle CPU's LED/statistics outputs.
- Latches the syscall-34 LED word and selects one of four 32-bit values: LED word, total cycles, unconditional branch count, conditional branch count.
- Shows the selected value as 8 hex digits on a time-multiplexed, active-low 7-segment display.
- Sits between the CPU top and the board's anode/segment pins.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit; legal range >= 1
FLASH_CYCLES, 1000000, clk cycles digit-0 dp stays lit after an LED latch; legal range >= 1

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
led_cpu_enable  input  1  CPU strobe: led_data_in valid this cycle
led_data_in  input  32  LED word from CPU
total_cycles  input  32  CPU cycle counter
uncondi_branch_num  input  32  CPU unconditional branch counter
condi_branch_num  input  32  CPU conditional branch counter
disp_sel  input  2  source select: 0 LED word, 1 total_cycles, 2 uncondi, 3 condi
an  output  8  digit anodes, active low, one-hot; bit i = digit i (0 = least significant nibble)
seg  output  8  segments, active low; [7]=dp, [6:0]=gfedcba

Behaviour:
- Reset (rst=1 at edge) values:
  - led_reg=0, div_cnt=0, dig_idx=0, disp_word=0, flash_cnt=0.
  - an=8'hFF, seg=8'hFF (display dark).
- LED latch:
  - led_cpu_enable=1 at an edge -> led_reg<=led_data_in; flash_cnt<=FLASH_CYCLES.
  - Otherwise led_reg holds and flash_cnt decrements, saturating at 0.
  - Repeated strobes reload both each time.
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and dig_idx advances (7 wraps to 0).
  - SCAN_DIV=1: dig_idx advances every cycle.
- Snapshot, for tear-free display:
  - disp_word is loaded only when div_cnt==SCAN_DIV-1 and dig_idx==7, i.e. exactly as dig_idx wraps to 0.
  - Loaded value: the mux of led_reg / total_cycles / uncondi_branch_num / condi_branch_num per disp_sel.
  - disp_sel changes mid-frame take effect at the next frame boundary only.
- Latch/snapshot on the same edge: the snapshot takes the pre-edge led_reg; the new value appears in the next frame.
- Outputs are registered, updated every cycle from the current dig_idx and disp_word (one-cycle latency):
  - an <= ~(8'b1 << dig_idx).
  - seg[6:0] <= hex decode of disp_word[4*dig_idx+3 : 4*dig_idx].
  - seg[7] <= 0 (dp lit) iff dig_idx==0 and flash_cnt!=0; else 1.
- Hex decode, nibble -> seg[6:0]:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - With dp off this gives seg=C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- First post-reset cycle: an=FE, seg=C0. Digit 1 is lit after SCAN_DIV cycles.
- Reset mid-frame: all state returns to reset values at that edge; the next frame starts from digit 0.
- Counter inputs wrap freely upstream; no width conversion is performed.

Optional Feature:
- Macro: LED_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero nibble of disp_word output seg=8'hFF (anode still scanned).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blank mask is computed from disp_word, so it is stable for a whole frame.
- Undefined: all 8 digits always shown, including leading zeros.

Test Plan (SCAN_DIV=4, FLASH_CYCLES=10 unless noted):
- Reset: hold rst 2 cycles then release. Required: an=FF, seg=FF during reset; first cycle after an=FE, seg=C0; an=FD after 4 more cycles.
- LED latch: disp_sel=0, pulse led_cpu_enable with led_data_in=32'h1234ABCD, wait one full frame boundary.
  - Digits 0..7 show seg=A1, C6, 83, 88, 99, B0, A4, F9.
  - Digit-0 dp is 0 while flash_cnt>0 and returns to 1 after 10 cycles.
- Snapshot tearing: frame showing total_cycles; switch disp_sel to 2 at dig_idx=3. Required: digits 4..7 still from total_cycles snapshot; uncondi value appears only from the next dig_idx=0.
- Simultaneous events: led_cpu_enable with 32'hFFFFFFFF on the snapshot edge. Required: that frame shows the old led_reg (0 -> C0 on all digits); the next frame shows 8E on all digits.
- Reset mid-scan: assert rst at dig_idx=5. Required: outputs FF at the next edge; scan restarts at FE; disp_word=0.
- LED_ZERO_BLANK_EN defined, led word 32'h000000A5: digits 0,1 show 92, 88; digits 2..7 show seg=FF. Undefined: digits 2..7 show C0.

Source files
------------

// File: rtl/led_display_ctrl_if.sv
// led_display_ctrl_if: groups the CPU-side statistics/LED signals and the
// board-side anode/segment pins of the LED display controller.
//
// Handshake: led_cpu_enable is a single-cycle strobe with no back-pressure.
// led_data_in is valid only in a cycle where led_cpu_enable=1. The
// controller always accepts it at that rising edge, so there is no ready.
// The three counter inputs and disp_sel are level signals, sampled whenever
// a display frame is snapshotted.
interface led_display_ctrl_if;
    logic        led_cpu_enable;
    logic [31:0] led_data_in;
    logic [31:0] total_cycles;
    logic [31:0] uncondi_branch_num;
    logic [31:0] condi_branch_num;
    logic [1:0]  disp_sel;
    logic [7:0]  an;
    logic [7:0]  seg;

    // CPU/board side: drives the strobe, counters and select, and sees the pins.
    modport master (
        output led_cpu_enable,
        output led_data_in,
        output total_cycles,
        output uncondi_branch_num,
        output condi_branch_num,
        output disp_sel,
        input  an,
        input  seg
    );

    // Display controller side.
    modport slave (
        input  led_cpu_enable,
        input  led_data_in,
        input  total_cycles,
        input  uncondi_branch_num,
        input  condi_branch_num,
        input  disp_sel,
        output an,
        output seg
    );
endinterface

// File: rtl/led_display_ctrl.sv
// led_display_ctrl: latches the CPU's LED word and shows one of four 32-bit
// values as 8 hex digits on a time-multiplexed, active-low 7-segment display.
//
// Each digit stays lit for SCAN_DIV clocks. The displayed word is
// snapshotted once per frame, as the scan wraps from digit 7 to digit 0, so
// a frame never mixes two values. The digit-0 decimal point flashes for
// FLASH_CYCLES clocks after every LED latch.
//
// Optional build macro LED_ZERO_BLANK_EN: when defined, leading-zero digits
// are blanked. Digit 0 is always shown. When it is undefined, all 8 digits
// are shown.
module led_display_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int FLASH_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    led_display_ctrl_if.slave bus
);

    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

    logic [31:0]        led_reg;
    logic [FLASH_W-1:0] flash_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         dig_idx;
    logic [31:0]        disp_word;
    logic [31:0]        src_word;
    logic [3:0]         nibble;
    logic               div_wrap;
    logic               frame_end;
    logic               dp_on;
    logic               blank;

    // Hex nibble to active-low gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign frame_end = div_wrap && (dig_idx == 3'd7);

    // LED word latch and dp flash timer: every strobe reloads both.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg   <= '0;
            flash_cnt <= '0;
        end else if (bus.led_cpu_enable) begin
            led_reg   <= bus.led_data_in;
            flash_cnt <= FLASH_LOAD;
        end else if (flash_cnt != '0) begin
            flash_cnt <= flash_cnt - 1'b1;
        end
    end

    // Scan timing: a clock divider that steps the digit index; 7 wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            dig_idx <= dig_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Source select for the next frame's snapshot.
    always_comb begin
        src_word = led_reg;
        case (bus.disp_sel)
            2'd0:    src_word = led_reg;
            2'd1:    src_word = bus.total_cycles;
            2'd2:    src_word = bus.uncondi_branch_num;
            default: src_word = bus.condi_branch_num;
        endcase
    end

    // Frame snapshot. On the same edge as a latch it takes the old led_reg,
    // so a new LED word shows up one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_word <= '0;
        end else if (frame_end) begin
            disp_word <= src_word;
        end
    end

    assign nibble = disp_word[{dig_idx, 2'b00} +: 4];
    assign dp_on  = (dig_idx == 3'd0) && (flash_cnt != '0);

`ifdef LED_ZERO_BLANK_EN
    logic [2:0] lead_idx;

    // Position of the most significant nonzero nibble (0 when the word is 0).
    always_comb begin
        lead_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (disp_word[4*i +: 4] != 4'h0) begin
                lead_idx = 3'(i);
            end
        end
    end

    assign blank = (dig_idx > lead_idx);
`else
    assign blank = 1'b0;
`endif

    // Registered pin drivers: dark during reset, one-cycle latency otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an  <= 8'hFF;
            bus.seg <= 8'hFF;
        end else begin
            bus.an  <= ~(8'b1 << dig_idx);
            bus.seg <= blank ? 8'hFF : {~dp_on, hex_to_seg(nibble)};
        end
    end

endmodule

// File: tb/tb_led_display_ctrl.sv
// tb_led_display_ctrl: directed stimulus for led_display_ctrl with
// SCAN_DIV=4, FLASH_CYCLES=10.
// A cycle-level model that works from elapsed time since reset is compared
// against the pins on every cycle. Literal checks pin down specific digits.
module tb_led_display_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int FLASH_CYCLES = 10;
    localparam int FRAME        = 8 * SCAN_DIV;

    logic clk;
    logic rst;

    led_display_ctrl_if bus_if ();

    led_display_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // Active-low seg patterns with dp off, indexed by nibble value.
    logic [7:0] seg_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_t counts the non-reset edges since the last reset. Frame timing is
    // derived from it by division.
    int          m_t;
    int          m_flash;
    logic [31:0] m_led;
    logic [31:0] m_word;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        int dig;
        logic [3:0] nib;
        if (rst) begin
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
            m_t     = 0;
            m_flash = 0;
            m_led   = '0;
            m_word  = '0;
        end else begin
            dig     = (m_t / SCAN_DIV) % 8;
            nib     = 4'((m_word >> (4 * dig)) & 32'hF);
            exp_an  = ~(8'h01 << dig);
            exp_seg = seg_tab[nib];
            if (dig == 0 && m_flash > 0) exp_seg[7] = 1'b0;
`ifdef LED_ZERO_BLANK_EN
            if (dig != 0 && (m_word >> (4 * dig)) == 32'h0) exp_seg = 8'hFF;
`endif
            if (m_t % FRAME == FRAME - 1) begin
                case (bus_if.disp_sel)
                    2'd0:    m_word = m_led;
                    2'd1:    m_word = bus_if.total_cycles;
                    2'd2:    m_word = bus_if.uncondi_branch_num;
                    default: m_word = bus_if.condi_branch_num;
                endcase
            end
            if (bus_if.led_cpu_enable) begin
                m_led   = bus_if.led_data_in;
                m_flash = FLASH_CYCLES;
            end else if (m_flash > 0) begin
                m_flash--;
            end
            m_t++;
        end
        m_valid = 1'b1;
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", bus_if.an, exp_an);
            check("model_seg", bus_if.seg, exp_seg);
        end
    end

    // ---------------- driver tasks ----------------
    // Advance (at negedges) until the model has seen k edges since reset.
    task automatic goto_edge(input int k);
        int n;
        n = 0;
        while (m_t != k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_t != k) begin
            checks++;
            errors++;
            $display("FAIL goto_edge: got %0d expected %0d", m_t, k);
        end
    endtask

    task automatic expect_at(input string name, input int k,
                             input logic [7:0] an_e, input logic [7:0] seg_e);
        goto_edge(k);
        check({name, "_an"}, bus_if.an, an_e);
        check({name, "_seg"}, bus_if.seg, seg_e);
    endtask

    task automatic strobe_led(input logic [31:0] data);
        bus_if.led_cpu_enable = 1'b1;
        bus_if.led_data_in    = data;
        @(negedge clk);
        bus_if.led_cpu_enable = 1'b0;
        bus_if.led_data_in    = '0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] led_exp [0:7] = '{8'h21, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] lead_exp;

    initial begin
        rst                       = 1'b1;
        bus_if.led_cpu_enable     = 1'b0;
        bus_if.led_data_in        = '0;
        bus_if.total_cycles       = '0;
        bus_if.uncondi_branch_num = '0;
        bus_if.condi_branch_num   = '0;
        bus_if.disp_sel           = 2'd0;

        // Reset held two cycles: display dark.
        @(negedge clk);
        check("rst_an_0", bus_if.an, 8'hFF);
        check("rst_seg_0", bus_if.seg, 8'hFF);
        @(negedge clk);
        check("rst_an_1", bus_if.an, 8'hFF);
        check("rst_seg_1", bus_if.seg, 8'hFF);
        rst = 1'b0;
        expect_at("first", 1, 8'hFE, 8'hC0);
        expect_at("digit1", 5, 8'hFD, 8'hC0);

        // LED latch at edge 31, snapshot at edge 32: shown from edge 33 on.
        goto_edge(30);
        strobe_led(32'h1234ABCD);
        for (int i = 0; i < 8; i++) begin
            expect_at("led_digit", 33 + 4 * i, ~(8'h01 << i), led_exp[i]);
        end
        expect_at("led_dp_off", 65, 8'hFE, 8'hA1);

        // Snapshot tearing: select total_cycles, then switch mid-frame.
        bus_if.disp_sel           = 2'd1;
        bus_if.total_cycles       = 32'h76543210;
        bus_if.uncondi_branch_num = 32'h89ABCDEF;
        bus_if.condi_branch_num   = 32'h13579BDF;
        expect_at("tot_d0", 97, 8'hFE, 8'hC0);
        goto_edge(110);
        bus_if.disp_sel = 2'd2;
        expect_at("tear_d4", 113, 8'hEF, 8'h99);
        expect_at("tear_d7", 125, 8'h7F, 8'hF8);
        expect_at("unc_d0", 129, 8'hFE, 8'h8E);
        expect_at("unc_d1", 133, 8'hFD, 8'h86);

        // Reset mid-scan while digit 5 is lit.
        goto_edge(150);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", bus_if.an, 8'hFF);
        check("midrst_seg", bus_if.seg, 8'hFF);
        rst             = 1'b0;
        bus_if.disp_sel = 2'd0;
        expect_at("midrst_first", 1, 8'hFE, 8'hC0);

        // Latch and snapshot on the same edge: this frame still shows 0.
        goto_edge(31);
        strobe_led(32'hFFFFFFFF);
        expect_at("sim_d0_dp", 33, 8'hFE, 8'h40);
        expect_at("sim_d1", 37, 8'hFD, 8'hC0);
        expect_at("sim_next_d0", 65, 8'hFE, 8'h8E);
        expect_at("sim_next_d7", 93, 8'h7F, 8'h8E);

        // Leading zeros.
`ifdef LED_ZERO_BLANK_EN
        lead_exp = 8'hFF;
`else
        lead_exp = 8'hC0;
`endif
        goto_edge(100);
        strobe_led(32'h000000A5);
        expect_at("a5_d0", 129, 8'hFE, 8'h92);
        expect_at("a5_d1", 133, 8'hFD, 8'h88);
        expect_at("a5_d2", 137, 8'hFB, lead_exp);
        expect_at("a5_d7", 157, 8'h7F, lead_exp);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
